fetch_controller: RTL

Sequences the 256×16 combinational instruction memory for the RISC FSM core. Holds the program counter, drives the memory address, and registers the returned word into an instruction register. Presents that instruction to the execute FSM through a valid/ready handshake and accepts branch redirects. Stops fetching when it latches a HALT-opcode word.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_controller_if.sv | 35 +++
 rtl/pc_counter.sv | 49 ++++
 rtl/fetch_controller.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch block:
//                fetch FSM state encoding, opcode field position and the
//                RISC core opcode values.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        VALID  = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    // Opcode field location inside an instruction word
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 13;

    // Opcode values
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b111;

endpackage
`default_nettype wire

// File: rtl/fetch_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_controller_if
//  Description : Bus between the fetch controller, the instruction memory and
//                the execute FSM.
//                  instr_addr / instr_data : combinational memory read port
//                  ir / ir_pc / ir_valid / ir_ready : instruction handshake
//                  br_valid / br_target : branch redirect from execute
//                master = fetch controller, slave = memory/execute side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_controller_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] instr_addr;
    logic [DATA_W-1:0] instr_data;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic              br_valid;
    logic [ADDR_W-1:0] br_target;

    modport master (
        output instr_addr, ir, ir_pc, ir_valid,
        input  instr_data, ir_ready, br_valid, br_target
    );

    modport slave (
        input  instr_addr, ir, ir_pc, ir_valid,
        output instr_data, ir_ready, br_valid, br_target
    );
endinterface
`default_nettype wire

// File: rtl/pc_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pc_counter
//  Description : Program counter. Loadable, wrapping ADDR_W-bit register.
//                Load has priority over increment; increment wraps modulo
//                2^ADDR_W with no carry out.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                load_i        - load load_val_i this cycle
//                load_val_i    - value to load
//                inc_i         - increment this cycle
//                pc_o          - current program counter
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_counter #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              load_i,
    input  wire logic [ADDR_W-1:0] load_val_i,
    input  wire logic              inc_i,
    output logic      [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_controller
//  Description : Instruction fetch sequencer. Drives the combinational
//                instruction memory from the PC, registers the returned word
//                into the instruction register, presents it to execute via a
//                valid/ready handshake, accepts branch redirects and stops
//                after a HALT instruction is consumed.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                start     - begin fetching from RESET_PC (IDLE/HALTED only)
//                halted    - HALT consumed, fetch stopped
//                busy      - FSM in FETCH or VALID
//                bus       - memory port, instruction handshake, redirect
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter logic [2:0]        HALT_OP  = 3'b111
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           start,
    output logic                halted,
    output logic                busy,
    fetch_controller_if.master  bus
);

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic [ADDR_W-1:0] pc;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic              pc_inc;
    logic              ir_is_halt;

    pc_counter #(
        .ADDR_W    (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    assign ir_is_halt = (ir_q[OP_MSB:OP_LSB] == HALT_OP);

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        pc_load     = 1'b0;
        pc_load_val = RESET_PC;
        pc_inc      = 1'b0;

        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    pc_load = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (bus.br_valid) begin
                    pc_load     = 1'b1;
                    pc_load_val = bus.br_target;
                end else begin
                    ir_d    = bus.instr_data;
                    ir_pc_d = pc;
                    pc_inc  = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                // Redirect wins over a same-cycle consume: the current word
                // is still taken by execute, but the word at pc is dropped.
                if (bus.br_valid) begin
                    pc_load     = 1'b1;
                    pc_load_val = bus.br_target;
                    state_d     = FETCH;
                end else if (bus.ir_ready) begin
                    if (ir_is_halt) begin
                        state_d = HALTED;
                    end else begin
                        ir_d    = bus.instr_data;
                        ir_pc_d = pc;
                        pc_inc  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= '0;
            ir_pc_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
        end
    end

    assign bus.instr_addr = pc;
    assign bus.ir         = ir_q;
    assign bus.ir_pc      = ir_pc_q;
    assign bus.ir_valid   = (state_q == VALID);
    assign halted         = (state_q == HALTED);
    assign busy           = (state_q == FETCH) || (state_q == VALID);

endmodule
`default_nettype wire
